pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised game core for the VGA pong design, the successor to the fixed single-paddle pixel generator. It sits between the debouncers / `vga_controller` and the VGA port. It owns 1 or 2 paddles, ball physics, per-player score counters and a serve/point/game-over state machine. It also produces the registered 12-bit pixel colour for the current scan position.

## Interface
- `H_PIX`, 640, active pixels per line
- `V_PIX`, 480, active lines per frame
- `NUM_PLAYERS`, 2, 1 (right side is a wall) or 2
- `PADDLE_H`, 72, paddle height in pixels
- `PADDLE_W`, 4, paddle width in pixels
- `BALL_SIZE`, 8, square ball edge in pixels
- `PADDLE_STEP`, 3, paddle pixels moved per frame
- `BALL_STEP`, 2, ball pixels moved per axis per frame
- `WIN_SCORE`, 9, score that ends the game (≤ 2^`SCORE_W`−1)
- `SCORE_W`, 4, score counter width

Ports:
- `clk` in 1: system clock (100 MHz)
- `reset` in 1: one clock; reset is asynchronous and active-low
- `p_tick` in 1: pixel-enable strobe from `vga_controller`
- `video_on` in 1: active-area flag
- `x`, `y` in 10 each: current scan position
- `up`, `down` in `NUM_PLAYERS` each: debounced buttons; bit 0 = left player
- `serve` in 1: debounced serve/restart button
- `rgb` out 12: registered pixel colour
- `score` out `NUM_PLAYERS*SCORE_W`: player p occupies bits [p*SCORE_W +: SCORE_W]
- `game_over` out 1: high in state OVER
- `frame_tick` out 1: one-cycle refresh strobe (debug)

## Operation
- `frame_tick` = `p_tick` && x==0 && y==`V_PIX`. All game state updates only on `frame_tick`. Inputs are sampled on that cycle.
- Paddles:
  - Left paddle x span is [32, 32+`PADDLE_W`−1]; right paddle x span is [`H_PIX`−36, `H_PIX`−36+`PADDLE_W`−1].
  - Paddle y moves ±`PADDLE_STEP` per frame. up&&down together means hold.
  - Paddle y clamps to [0, `V_PIX`−`PADDLE_H`]; no wrap.
  - Paddles move in every state except OVER.
- Ball: top-left (bx,by); direction bits dx (1 = right), dy (1 = down).
  - If by ≤ `BALL_STEP` then dy←1. If by+`BALL_SIZE` ≥ `V_PIX`−`BALL_STEP` then dy←0.
  - Paddle hit: ball moving toward a paddle, x spans overlap, and y spans overlap → dx flips that frame; position still advances.
  - Miss: bx ≤ `BALL_STEP` (left) or bx+`BALL_SIZE` ≥ `H_PIX`−`BALL_STEP` (right) → point to the opposite player.
  - When `NUM_PLAYERS`==1, the right edge reflects as a wall and only player 0 can lose; `score` counts successful returns.
  - When a paddle hit and a wall hit occur in the same frame, both bits update.
- FSM states (2-bit):
  - SERVE: ball is parked at centre. `serve`=1 → PLAY, with dx toward the player who lost the last point (dx=0 after reset).
  - PLAY: physics runs. On a miss: increment the scorer's counter (saturating). If the new score == `WIN_SCORE` → OVER, else → POINT.
  - POINT: ball frozen for 60 frames (6-bit counter), then → SERVE with the ball re-centred.
  - OVER: ball and paddles frozen. `serve`=1 → SERVE with all scores cleared.
- Render priority: ball > paddles > top/bottom 4-px walls > background. When `video_on`=0 → 12'h000.
- Reset values (asynchronous, while `reset`=0):
  - `rgb`=0, `score`=0, `game_over`=0, `frame_tick`=0, state=SERVE.
  - Ball at (`H_PIX`/2−`BALL_SIZE`/2, `V_PIX`/2−`BALL_SIZE`/2), dx=0, dy=1.
  - Paddles at y=(`V_PIX`−`PADDLE_H`)/2.
- Reset mid-game returns everything to the reset values; no partial state is retained.

## Timing
- `rgb` is updated only when `p_tick`=1. It reflects the x/y/`video_on` sampled on that same cycle and appears one clock later; it holds between ticks.
- Game state changes exactly one clock after `frame_tick`. The frame displayed afterward uses the new positions.
- `score` and `game_over` are registered and change in the cycle after the deciding `frame_tick`.
- `serve` is level-sampled at `frame_tick` only; holding it across the SERVE→PLAY transition has no further effect.

## Structure
- Package `pong_pkg`:
  - FSM state encoding.
  - Colour constants (BALL 12'hF00, PADDLE 12'h0F0, WALL 12'hFFF, BG 12'h00F).
  - Paddle x offsets (32, 36).
  - POINT_HOLD=60.
- One sub-module, `pong_paddle`: holds one paddle's y register with step and clamp logic. It is instantiated `NUM_PLAYERS` times in a generate loop.
- Ball, FSM and render logic live in `pong_engine`.

## Test plan
- Reset with `up`=`down`=0, then 3 frames → both paddles remain at y=204, ball at (316,236), `rgb`=0 during blanking.
- `up[0]` held for 100 frames → left paddle y clamps at 0 and never wraps; `down[0]` for 200 frames → y=408.
- `serve` pulse, no paddle movement (`NUM_PLAYERS`=2) → ball exits left, `score[7:4]`=1, POINT for 60 frames, then SERVE with ball re-centred and dx=0.
- Paddle 0 placed over the ball path → dx flips to 1 when overlap occurs at bx≈36; score unchanged.
- Force 9 points to player 1 → `game_over`=1 on the 9th point, ball frozen; `serve` → scores 0, state SERVE.
- Drive x=320,y=240 (ball centre) with `video_on`=1 and a `p_tick` → `rgb`=12'hF00 one clock later; with `video_on`=0 → 12'h000.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared FSM encoding, colours and geometry for the pong core
package pong_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam logic [11:0] COL_BALL   = 12'hF00;
  localparam logic [11:0] COL_PADDLE = 12'h0F0;
  localparam logic [11:0] COL_WALL   = 12'hFFF;
  localparam logic [11:0] COL_BG     = 12'h00F;

  localparam int PAD_X_LEFT      = 32;
  localparam int PAD_X_RIGHT_OFF = 36;
  localparam int POINT_HOLD      = 60;
  localparam int WALL_H          = 4;

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - one paddle's vertical position with per-frame step and clamp
module pong_paddle
  import pong_pkg::*;
#(
  parameter int V_PIX       = 480,
  parameter int PADDLE_H    = 72,
  parameter int PADDLE_STEP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [9:0] y_o
);

  localparam logic [9:0] Y_MAX  = 10'(V_PIX - PADDLE_H);
  localparam logic [9:0] Y_INIT = 10'((V_PIX - PADDLE_H) / 2);
  localparam logic [9:0] STEP   = 10'(PADDLE_STEP);

  logic [9:0] y_q, y_d;

  always_comb begin
    y_d = y_q;
    if (move_i && up_i && !down_i) begin
      y_d = (y_q < STEP) ? 10'd0 : y_q - STEP;
    end else if (move_i && down_i && !up_i) begin
      y_d = (y_q + STEP > Y_MAX) ? Y_MAX : y_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) y_q <= Y_INIT;
    else        y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - pong game core: paddles, ball physics, scoring FSM and pixel colour
module pong_engine
  import pong_pkg::*;
#(
  parameter int H_PIX       = 640,
  parameter int V_PIX       = 480,
  parameter int NUM_PLAYERS = 2,
  parameter int PADDLE_H    = 72,
  parameter int PADDLE_W    = 4,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_STEP = 3,
  parameter int BALL_STEP   = 2,
  parameter int WIN_SCORE   = 9,
  parameter int SCORE_W     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           p_tick,
  input  logic                           video_on,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  input  logic [NUM_PLAYERS-1:0]         up,
  input  logic [NUM_PLAYERS-1:0]         down,
  input  logic                           serve,
  output logic [11:0]                    rgb,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic                           game_over,
  output logic                           frame_tick
);

  localparam logic [9:0] BX_INIT = 10'(H_PIX / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BY_INIT = 10'(V_PIX / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BSTEP   = 10'(BALL_STEP);
  localparam logic [9:0] BS      = 10'(BALL_SIZE);
  localparam logic [9:0] BS1     = 10'(BALL_SIZE - 1);
  localparam logic [9:0] PW1     = 10'(PADDLE_W - 1);
  localparam logic [9:0] PH1     = 10'(PADDLE_H - 1);
  localparam logic [9:0] PADX_L  = 10'(PAD_X_LEFT);
  localparam logic [9:0] PADX_R  = 10'(H_PIX - PAD_X_RIGHT_OFF);
  localparam logic [9:0] H_LIM   = 10'(H_PIX - BALL_STEP);
  localparam logic [9:0] V_LIM   = 10'(V_PIX - BALL_STEP);
  localparam logic [9:0] V_LAST  = 10'(V_PIX);
  localparam logic [9:0] WALL_LO = 10'(WALL_H);
  localparam logic [9:0] WALL_HI = 10'(V_PIX - WALL_H);
  localparam logic [5:0] HOLD_LAST = 6'(POINT_HOLD - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_e                         state_q, state_d;
  logic [9:0]                     bx_q, bx_d, by_q, by_d;
  logic                           dx_q, dx_d, dy_q, dy_d;
  logic                           loser_q, loser_d;
  logic [5:0]                     hold_q, hold_d;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_q, score_d;
  logic [11:0]                    rgb_q, rgb_d;
  logic [9:0]                     pad_y [NUM_PLAYERS];

  logic ft, paddles_move;
  assign ft           = p_tick && (x == 10'd0) && (y == V_LAST);
  assign paddles_move = ft && (state_q != ST_OVER);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pad
    pong_paddle #(
      .V_PIX      (V_PIX),
      .PADDLE_H   (PADDLE_H),
      .PADDLE_STEP(PADDLE_STEP)
    ) u_pad (
      .clk   (clk),
      .reset (reset),
      .move_i(paddles_move),
      .up_i  (up[g]),
      .down_i(down[g]),
      .y_o   (pad_y[g])
    );
  end

  // Collision terms use the positions held before this frame's move.
  logic hit_l, hit_r, wall_r, miss_l, miss_r, dx_n, dy_n;
  always_comb begin
    hit_l  = !dx_q && (bx_q <= PADX_L + PW1) && (bx_q + BS1 >= PADX_L) &&
             (by_q <= pad_y[0] + PH1) && (by_q + BS1 >= pad_y[0]);
    hit_r  = (NUM_PLAYERS == 2) && dx_q && (bx_q <= PADX_R + PW1) && (bx_q + BS1 >= PADX_R) &&
             (by_q <= pad_y[NUM_PLAYERS-1] + PH1) && (by_q + BS1 >= pad_y[NUM_PLAYERS-1]);
    wall_r = (NUM_PLAYERS == 1) && dx_q && (bx_q + BS >= H_LIM);
    miss_l = (bx_q <= BSTEP);
    miss_r = (NUM_PLAYERS == 2) && (bx_q + BS >= H_LIM);
    dx_n = dx_q;
    if (hit_l) dx_n = 1'b1;
    if (hit_r || wall_r) dx_n = 1'b0;
    dy_n = dy_q;
    if (by_q <= BSTEP)          dy_n = 1'b1;
    else if (by_q + BS >= V_LIM) dy_n = 1'b0;
  end

  int                 sidx;
  logic [SCORE_W-1:0] cur, nxt;
  logic               recentre;

  always_comb begin
    state_d  = state_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    loser_d  = loser_q;
    hold_d   = hold_q;
    score_d  = score_q;
    recentre = 1'b0;
    sidx     = (NUM_PLAYERS == 2 && miss_l) ? 1 : 0;
    cur      = score_q[sidx*SCORE_W +: SCORE_W];
    nxt      = (cur == {SCORE_W{1'b1}}) ? cur : cur + 1'b1;
    unique case (state_q)
      ST_SERVE: begin
        if (ft && serve) begin
          state_d = ST_PLAY;
          dx_d    = loser_q;
        end
      end
      ST_PLAY: begin
        if (ft) begin
          if (miss_l || miss_r) begin
            loser_d = miss_r;
            if (NUM_PLAYERS == 2) begin
              score_d[sidx*SCORE_W +: SCORE_W] = nxt;
              state_d = (nxt == WIN) ? ST_OVER : ST_POINT;
            end else begin
              state_d = ST_POINT;
            end
          end else begin
            dx_d = dx_n;
            dy_d = dy_n;
            bx_d = dx_n ? bx_q + BSTEP : bx_q - BSTEP;
            by_d = dy_n ? by_q + BSTEP : by_q - BSTEP;
            // Single-player mode scores each successful return.
            if (NUM_PLAYERS == 1 && hit_l) begin
              score_d[SCORE_W-1:0] = nxt;
              if (nxt == WIN) state_d = ST_OVER;
            end
          end
        end
      end
      ST_POINT: begin
        if (ft) begin
          if (hold_q == HOLD_LAST) begin
            hold_d   = 6'd0;
            state_d  = ST_SERVE;
            recentre = 1'b1;
          end else begin
            hold_d = hold_q + 6'd1;
          end
        end
      end
      ST_OVER: begin
        if (ft && serve) begin
          state_d  = ST_SERVE;
          score_d  = '0;
          recentre = 1'b1;
        end
      end
      default: state_d = ST_SERVE;
    endcase
    if (recentre) begin
      bx_d = BX_INIT;
      by_d = BY_INIT;
      dx_d = loser_q;
      dy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SERVE;
      bx_q    <= BX_INIT;
      by_q    <= BY_INIT;
      dx_q    <= 1'b0;
      dy_q    <= 1'b1;
      loser_q <= 1'b0;
      hold_q  <= 6'd0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      loser_q <= loser_d;
      hold_q  <= hold_d;
      score_q <= score_d;
    end
  end

  logic       ball_px, pad_px, wall_px;
  logic [9:0] xl;
  always_comb begin
    ball_px = (x >= bx_q) && (x <= bx_q + BS1) && (y >= by_q) && (y <= by_q + BS1);
    pad_px  = 1'b0;
    xl      = PADX_L;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      xl = (p == 0) ? PADX_L : PADX_R;
      if ((x >= xl) && (x <= xl + PW1) && (y >= pad_y[p]) && (y <= pad_y[p] + PH1)) pad_px = 1'b1;
    end
    wall_px = (y < WALL_LO) || (y >= WALL_HI);
    if (!video_on)    rgb_d = 12'h000;
    else if (ball_px) rgb_d = COL_BALL;
    else if (pad_px)  rgb_d = COL_PADDLE;
    else if (wall_px) rgb_d = COL_WALL;
    else              rgb_d = COL_BG;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rgb_q <= 12'h000;
    else if (p_tick) rgb_q <= rgb_d;
  end

  assign rgb        = rgb_q;
  assign score      = score_q;
  assign game_over  = (state_q == ST_OVER);
  assign frame_tick = ft;

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - directed self-checking bench for pong_engine
module tb_pong_engine;
  import pong_pkg::*;

  logic        clk = 1'b0;
  logic        reset, p_tick, video_on, serve;
  logic [9:0]  x, y;
  logic [1:0]  up, down;
  logic [11:0] rgb;
  logic [7:0]  score;
  logic        game_over, frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  pong_engine dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .video_on  (video_on),
    .x         (x),
    .y         (y),
    .up        (up),
    .down      (down),
    .serve     (serve),
    .rgb       (rgb),
    .score     (score),
    .game_over (game_over),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic frame();
    @(negedge clk);
    p_tick = 1'b1; x = 10'd0; y = 10'd480; video_on = 1'b0;
    @(negedge clk);
    p_tick = 1'b0; x = 10'd1; y = 10'd0;
  endtask

  task automatic pixel(input logic [9:0] px, input logic [9:0] py, input logic von);
    @(negedge clk);
    p_tick = 1'b1; x = px; y = py; video_on = von;
    @(negedge clk);
    p_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; up = 2'b00; down = 2'b00; serve = 1'b0;
    p_tick = 1'b0; video_on = 1'b0; x = 10'd1; y = 10'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; serve = 1'b0;
    x = 10'd1; y = 10'd0; up = 2'b00; down = 2'b00;
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'(rgb), 32'h000);
    check("rst_score", 32'(score), 32'h00);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_SERVE));
    reset = 1'b1;

    // Idle frames: nothing moves.
    repeat (3) frame();
    check("idle_pad0", 32'(dut.pad_y[0]), 32'd204);
    check("idle_pad1", 32'(dut.pad_y[1]), 32'd204);
    check("idle_bx", 32'(dut.bx_q), 32'd316);
    check("idle_by", 32'(dut.by_q), 32'd236);
    check("idle_dy", 32'(dut.dy_q), 32'd1);

    // Rendering.
    pixel(10'd320, 10'd240, 1'b0);
    check("rgb_blank", 32'(rgb), 32'h000);
    pixel(10'd320, 10'd240, 1'b1);
    check("rgb_ball", 32'(rgb), 32'hF00);
    @(negedge clk);
    x = 10'd100; y = 10'd100; video_on = 1'b0;
    @(negedge clk);
    check("rgb_hold", 32'(rgb), 32'hF00);
    pixel(10'd34, 10'd210, 1'b1);
    check("rgb_pad_l", 32'(rgb), 32'h0F0);
    pixel(10'd607, 10'd275, 1'b1);
    check("rgb_pad_r", 32'(rgb), 32'h0F0);
    pixel(10'd100, 10'd2, 1'b1);
    check("rgb_wall_top", 32'(rgb), 32'hFFF);
    pixel(10'd100, 10'd476, 1'b1);
    check("rgb_wall_bot", 32'(rgb), 32'hFFF);
    pixel(10'd100, 10'd100, 1'b1);
    check("rgb_bg", 32'(rgb), 32'h00F);

    // Paddle clamps at both ends; up&&down holds.
    up = 2'b01;
    repeat (100) frame();
    check("pad0_top", 32'(dut.pad_y[0]), 32'd0);
    check("pad1_still", 32'(dut.pad_y[1]), 32'd204);
    up = 2'b00; down = 2'b01;
    repeat (200) frame();
    check("pad0_bot", 32'(dut.pad_y[0]), 32'd408);
    up = 2'b01;
    repeat (2) frame();
    check("pad0_both", 32'(dut.pad_y[0]), 32'd408);

    // Mid-game reset restores paddle.
    do_reset();
    check("rst_pad0", 32'(dut.pad_y[0]), 32'd204);

    // Serve, ball exits left, player 1 scores.
    serve = 1'b1;
    frame();
    check("serve_state", 32'(dut.state_q), 32'(ST_PLAY));
    check("serve_dx", 32'(dut.dx_q), 32'd0);
    frame();
    serve = 1'b0;
    check("serve_held", 32'(dut.state_q), 32'(ST_PLAY));
    check("first_bx", 32'(dut.bx_q), 32'd314);
    repeat (156) frame();
    check("pre_miss_bx", 32'(dut.bx_q), 32'd2);
    check("pre_miss_state", 32'(dut.state_q), 32'(ST_PLAY));
    frame();
    check("miss_state", 32'(dut.state_q), 32'(ST_POINT));
    check("miss_score", 32'(score), 32'h10);
    check("miss_bx", 32'(dut.bx_q), 32'd2);
    repeat (59) frame();
    check("point_hold", 32'(dut.state_q), 32'(ST_POINT));
    frame();
    check("point_end", 32'(dut.state_q), 32'(ST_SERVE));
    check("recentre_bx", 32'(dut.bx_q), 32'd316);
    check("recentre_by", 32'(dut.by_q), 32'd236);
    check("recentre_dx", 32'(dut.dx_q), 32'd0);

    // Eight more points to player 1 end the game.
    for (int i = 2; i <= 9; i++) begin
      serve = 1'b1;
      frame();
      serve = 1'b0;
      repeat (158) frame();
      if (i < 9) begin
        check("pt_score", 32'(score), 32'(i << 4));
        check("pt_state", 32'(dut.state_q), 32'(ST_POINT));
        repeat (60) frame();
      end
    end
    check("over_flag", 32'(game_over), 32'd1);
    check("over_score", 32'(score), 32'h90);
    up = 2'b01;
    repeat (3) frame();
    up = 2'b00;
    check("over_pad_frozen", 32'(dut.pad_y[0]), 32'd204);
    check("over_ball_frozen", 32'(dut.bx_q), 32'd2);
    serve = 1'b1;
    frame();
    serve = 1'b0;
    check("restart_score", 32'(score), 32'h00);
    check("restart_flag", 32'(game_over), 32'd0);
    check("restart_state", 32'(dut.state_q), 32'(ST_SERVE));
    check("restart_bx", 32'(dut.bx_q), 32'd316);

    // Paddle return: place paddle 0 on the ball path.
    do_reset();
    down = 2'b01;
    repeat (60) frame();
    down = 2'b00;
    check("hit_pad0", 32'(dut.pad_y[0]), 32'd384);
    serve = 1'b1;
    frame();
    serve = 1'b0;
    repeat (141) frame();
    check("pre_hit_bx", 32'(dut.bx_q), 32'd34);
    check("pre_hit_dx", 32'(dut.dx_q), 32'd0);
    frame();
    check("hit_dx", 32'(dut.dx_q), 32'd1);
    check("hit_bx", 32'(dut.bx_q), 32'd36);
    check("hit_by", 32'(dut.by_q), 32'd420);
    check("hit_score", 32'(score), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
